// File: rtl/jeff_scan_mux_pkg.sv
// Shared types and constants for the jeff_scan_mux channel selector.
// Holds the state enum, mode encodings and the disabled-output word helper.
package jeff_scan_mux_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    MANUAL   = 2'd1,
    SCAN     = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_WIDTH = 1024;

  // Word with the low 'width' bits set; callers truncate to their own WIDTH.
  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jeff_dwell_counter.sv
// Dwell-time up-counter: counts enabled cycles and pulses tc on the last one,
// wrapping to zero on that same edge. clr has priority over counting.
module jeff_dwell_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] count_reg;

  assign tc = en && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || tc) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jeff_scan_mux.sv
// Registered N-channel selector with active-low enable, true/inverted outputs
// and an auto-scan mode that rotates through the channels with a fixed dwell.
module jeff_scan_mux
  import jeff_scan_mux_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int DWELL    = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      en_n,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [WIDTH-1:0]          w,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam logic [WIDTH-1:0] ONES    = WIDTH'(all_ones(WIDTH));
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] ch_reg, ch_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [WIDTH-1:0] w_reg;
  logic             valid_reg, valid_next;
  logic             wrap_reg, wrap_next;

  logic             scan_run;
  logic             dwell_tc;
  logic [SEL_W-1:0] pick;
  logic [WIDTH-1:0] pick_data;
  logic             pick_ok;

  // en_n dominates; otherwise mode alone picks the state from any state.
  always_comb begin
    state_next = state_reg;
    if (en_n) begin
      state_next = DISABLED;
    end else if (mode == MODE_SCAN) begin
      state_next = SCAN;
    end else begin
      state_next = MANUAL;
    end
  end

  // Only an uninterrupted stay in SCAN keeps the dwell count; entry restarts it.
  assign scan_run = (state_reg == SCAN) && (state_next == SCAN);

  jeff_dwell_counter #(
    .MAX (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!scan_run),
    .en    (scan_run && !hold),
    .tc    (dwell_tc)
  );

  always_comb begin
    ch_next    = ch_reg;
    wrap_next  = 1'b0;
    pick       = sel;
    y_next     = ONES;
    valid_next = 1'b0;

    unique case (state_next)
      MANUAL: begin
        ch_next = sel;
        pick    = sel;
      end
      SCAN: begin
        if (!scan_run) begin
          ch_next = '0;
        end else if (dwell_tc) begin
          if (ch_reg == LAST_CH) begin
            ch_next   = '0;
            wrap_next = 1'b1;
          end else begin
            ch_next = ch_reg + SEL_W'(1);
          end
        end
        pick = ch_next;
      end
      default: ;
    endcase

    // An index past the last channel matches nothing and yields zero data.
    pick_data = '0;
    pick_ok   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pick == SEL_W'(k)) begin
        pick_data = d[k*WIDTH +: WIDTH];
        pick_ok   = 1'b1;
      end
    end

    if (state_next != DISABLED) begin
      y_next     = pick_data;
      valid_next = pick_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DISABLED;
      ch_reg    <= '0;
      y_reg     <= ONES;
      w_reg     <= '0;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      y_reg     <= y_next;
      w_reg     <= ~y_next;
      valid_reg <= valid_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign y     = y_reg;
  assign w     = w_reg;
  assign ch    = ch_reg;
  assign valid = valid_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_jeff_scan_mux.sv
// Self-checking bench for jeff_scan_mux: three configurations driven from one
// vector table through a scoreboard queue, plus an asynchronous reset sequence.
module tb_jeff_scan_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // inst 0: CHANNELS=8, DWELL=4
  logic [63:0] d8;
  logic [2:0]  sel8;
  logic        en_n8, mode8, hold8;
  logic [7:0]  y8, w8;
  logic [2:0]  ch8;
  logic        valid8, wrap8;

  // inst 1: CHANNELS=6, DWELL=4
  logic [47:0] d6;
  logic [2:0]  sel6;
  logic        en_n6, mode6, hold6;
  logic [7:0]  y6, w6;
  logic [2:0]  ch6;
  logic        valid6, wrap6;

  // inst 2: CHANNELS=4, DWELL=3
  logic [31:0] d4;
  logic [1:0]  sel4;
  logic        en_n4, mode4, hold4;
  logic [7:0]  y4, w4;
  logic [1:0]  ch4;
  logic        valid4, wrap4;

  jeff_scan_mux #(.CHANNELS(8), .WIDTH(8), .DWELL(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .sel(sel8), .en_n(en_n8), .mode(mode8),
    .hold(hold8), .y(y8), .w(w8), .ch(ch8), .valid(valid8), .wrap(wrap8)
  );

  jeff_scan_mux #(.CHANNELS(6), .WIDTH(8), .DWELL(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .d(d6), .sel(sel6), .en_n(en_n6), .mode(mode6),
    .hold(hold6), .y(y6), .w(w6), .ch(ch6), .valid(valid6), .wrap(wrap6)
  );

  jeff_scan_mux #(.CHANNELS(4), .WIDTH(8), .DWELL(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .d(d4), .sel(sel4), .en_n(en_n4), .mode(mode4),
    .hold(hold4), .y(y4), .w(w4), .ch(ch4), .valid(valid4), .wrap(wrap4)
  );

  typedef struct {
    int         inst;
    logic       en_n;
    logic       mode;
    logic       hold;
    logic [2:0] sel;
    logic [7:0] y;
    logic       valid;
    int         ch;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input int inst, input logic en_n, input logic mode,
                              input logic hold, input int sel, input logic [7:0] y,
                              input logic valid, input int ch, input logic wrap);
    vec_t v;
    v.inst = inst; v.en_n = en_n; v.mode = mode; v.hold = hold;
    v.sel = 3'(sel); v.y = y; v.valid = valid; v.ch = ch; v.wrap = wrap;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    case (v.inst)
      0: begin en_n8 = v.en_n; mode8 = v.mode; hold8 = v.hold; sel8 = v.sel; end
      1: begin en_n6 = v.en_n; mode6 = v.mode; hold6 = v.hold; sel6 = v.sel; end
      default: begin en_n4 = v.en_n; mode4 = v.mode; hold4 = v.hold; sel4 = v.sel[1:0]; end
    endcase
  endtask

  task automatic sample(input int inst, output logic [7:0] ay, output logic [7:0] aw,
                        output logic av, output logic [31:0] ach, output logic awr);
    case (inst)
      0: begin ay = y8; aw = w8; av = valid8; ach = 32'(ch8); awr = wrap8; end
      1: begin ay = y6; aw = w6; av = valid6; ach = 32'(ch6); awr = wrap6; end
      default: begin ay = y4; aw = w4; av = valid4; ach = 32'(ch4); awr = wrap4; end
    endcase
  endtask

  task automatic check_outputs(input string tag, input int row, input vec_t e);
    logic [7:0]  ay, aw, ew;
    logic        av, awr;
    logic [31:0] ach;
    sample(e.inst, ay, aw, av, ach, awr);
    ew = ~e.y;
    chk({tag, "_y"}, row, ay, e.y);
    chk({tag, "_w"}, row, aw, ew);
    chk({tag, "_valid"}, row, av, e.valid);
    chk({tag, "_ch"}, row, ach, e.ch);
    chk({tag, "_wrap"}, row, awr, e.wrap);
  endtask

  // Scan channel sequence: entry, wrap, a 5-cycle hold at ch 2, second wrap.
  int sch [30] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,
                   0,0,1,1,1,2,
                   2,2,2,2,2,
                   2,2,3,3,3,0};

  initial begin
    vec_t e;
    for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 6; k++) d6[k*8 +: 8] = 8'(8'hA0 + k);
    for (int k = 0; k < 4; k++) d4[k*8 +: 8] = 8'(8'h40 + k);
    {en_n8, en_n6, en_n4} = 3'b111;
    {mode8, mode6, mode4} = 3'b000;
    {hold8, hold6, hold4} = 3'b000;
    sel8 = 3'd0; sel6 = 3'd0; sel4 = 2'd0;

    // manual select on 8 channels, disable/re-enable, hold ignored
    add(0, 1'b1, 1'b0, 1'b0, 0, 8'hFF, 1'b0, 0, 1'b0);
    for (int k = 0; k < 8; k++) add(0, 1'b0, 1'b0, 1'b0, k, 8'(8'h10 + k), 1'b1, k, 1'b0);
    add(0, 1'b1, 1'b0, 1'b0, 2, 8'hFF, 1'b0, 7, 1'b0);
    add(0, 1'b0, 1'b0, 1'b1, 4, 8'h14, 1'b1, 4, 1'b0);
    // out-of-range select on 6 channels
    add(1, 1'b0, 1'b0, 1'b0, 2, 8'hA2, 1'b1, 2, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 7, 8'h00, 1'b0, 7, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 6, 8'h00, 1'b0, 6, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 5, 8'hA5, 1'b1, 5, 1'b0);
    add(1, 1'b0, 1'b0, 1'b0, 2, 8'hA2, 1'b1, 2, 1'b0);
    // scan with wrap and hold on 4 channels, dwell 3
    for (int i = 0; i < 30; i++)
      add(2, 1'b0, 1'b1, (i >= 19 && i <= 23), 3, 8'(8'h40 + sch[i]), 1'b1, sch[i],
          (i == 12 || i == 29));
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h41, 1'b1, 1, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h41, 1'b1, 1, 1'b0);
    // disable mid-dwell, then re-enable: scan restarts at channel 0
    add(2, 1'b1, 1'b1, 1'b0, 3, 8'hFF, 1'b0, 1, 1'b0);
    add(2, 1'b1, 1'b1, 1'b0, 3, 8'hFF, 1'b0, 1, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h41, 1'b1, 1, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h41, 1'b1, 1, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h41, 1'b1, 1, 1'b0);
    // mode drop on the terminal-count edge wins; re-entry restarts at 0
    add(2, 1'b0, 1'b0, 1'b0, 3, 8'h43, 1'b1, 3, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h40, 1'b1, 0, 1'b0);
    add(2, 1'b0, 1'b1, 1'b0, 3, 8'h41, 1'b1, 1, 1'b0);

    // asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #1;
    e.inst = 0; e.y = 8'hFF; e.valid = 1'b0; e.ch = 0; e.wrap = 1'b0;
    check_outputs("reset8", -1, e);
    e.inst = 2;
    check_outputs("reset4", -1, e);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_outputs("vec", i, e);
    end

    // reset pulsed mid-scan between edges, at ch 1
    #2 rst_n = 1'b0;
    #1;
    e.inst = 2; e.y = 8'hFF; e.valid = 1'b0; e.ch = 0; e.wrap = 1'b0;
    check_outputs("async_rst", -2, e);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    e.y = 8'h40; e.valid = 1'b1; e.ch = 0;
    check_outputs("post_rst", -3, e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
